snake_pos_decoder: RTL and testbench

- Monitor/decoder for the 20-step snake animation driven onto the two 4-digit 7-segment banks.
- Samples the segment and digit-select lines and recovers the one-hot step index as a binary position 0..19.
- Tracks rotation direction and counts completed laps.
- Flags illegal display patterns and non-adjacent jumps.
- Sits beside the display driver as an on-board self-check and a bench scoreboard.

---
 rtl/snake_pos_decoder.sv | 214 +++++++++++++++++++++
 tb/tb_snake_pos_decoder.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_pos_decoder.sv
`default_nettype none
// ============================================================================
// Module      : snake_pos_decoder
// Description : Recovers the 20-step snake position from two 4-digit 7-segment
//               banks, tracks direction and laps, and flags illegal patterns.
// Revision    : 1.0 - initial release
// ============================================================================
module snake_pos_decoder #(
    parameter int LAP_W = 8,
    parameter int ERR_W = 8
) (
    input  logic             clk_trl,
    input  logic             rst,
    input  logic             sample_en,
    input  logic [7:0]       a_to_g_left,
    input  logic [7:0]       a_to_g_right,
    input  logic [3:0]       leftseg,
    input  logic [3:0]       rightseg,
    output logic [4:0]       pos,
    output logic             pos_valid,
    output logic             dir,
    output logic             locked,
    output logic [LAP_W-1:0] lap_cnt,
    output logic             err_invalid,
    output logic             err_jump,
    output logic [ERR_W-1:0] err_cnt
);

    localparam logic [1:0] ST_HUNT    = 2'd0;
    localparam logic [1:0] ST_ACQUIRE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

    localparam logic [4:0] c_POS_LAST = 5'd19;

    logic [1:0]       r_state;
    logic [4:0]       r_pos;
    logic             r_pos_valid;
    logic             r_dir;
    logic [LAP_W-1:0] r_lap_cnt;
    logic             r_err_invalid;
    logic             r_err_jump;
    logic [ERR_W-1:0] r_err_cnt;

    logic             w_left_hit;
    logic [4:0]       w_left_pos;
    logic             w_right_hit;
    logic [4:0]       w_right_pos;
    logic             w_left_zero;
    logic             w_right_zero;
    logic             w_blank;
    logic             w_valid;
    logic             w_invalid;
    logic [4:0]       w_dec_pos;
    logic [4:0]       w_pos_next;
    logic [4:0]       w_pos_prev;
    logic             w_is_same;
    logic             w_is_next;
    logic             w_is_prev;
    logic             w_jump;
    logic             w_lap_step;
    logic             w_err_event;
    logic             w_err_sat;

    // Left-bank rows of the snake path
    always_comb begin
        w_left_hit = 1'b1;
        w_left_pos = 5'd0;
        case ({a_to_g_left, leftseg})
            {8'h80, 4'b1000}: w_left_pos = 5'd0;
            {8'h80, 4'b0100}: w_left_pos = 5'd1;
            {8'h80, 4'b0010}: w_left_pos = 5'd2;
            {8'h80, 4'b0001}: w_left_pos = 5'd3;
            {8'h10, 4'b0001}: w_left_pos = 5'd14;
            {8'h10, 4'b0010}: w_left_pos = 5'd15;
            {8'h10, 4'b0100}: w_left_pos = 5'd16;
            {8'h10, 4'b1000}: w_left_pos = 5'd17;
            {8'h08, 4'b1000}: w_left_pos = 5'd18;
            {8'h04, 4'b1000}: w_left_pos = 5'd19;
            default:          w_left_hit = 1'b0;
        endcase
    end

    // Right-bank rows of the snake path
    always_comb begin
        w_right_hit = 1'b1;
        w_right_pos = 5'd0;
        case ({a_to_g_right, rightseg})
            {8'h80, 4'b1000}: w_right_pos = 5'd4;
            {8'h80, 4'b0100}: w_right_pos = 5'd5;
            {8'h80, 4'b0010}: w_right_pos = 5'd6;
            {8'h80, 4'b0001}: w_right_pos = 5'd7;
            {8'h40, 4'b0001}: w_right_pos = 5'd8;
            {8'h20, 4'b0001}: w_right_pos = 5'd9;
            {8'h10, 4'b0001}: w_right_pos = 5'd10;
            {8'h10, 4'b0010}: w_right_pos = 5'd11;
            {8'h10, 4'b0100}: w_right_pos = 5'd12;
            {8'h10, 4'b1000}: w_right_pos = 5'd13;
            default:          w_right_hit = 1'b0;
        endcase
    end

    // A row only counts when the opposite bank is completely dark
    assign w_left_zero  = (a_to_g_left == 8'h00) && (leftseg == 4'b0000);
    assign w_right_zero = (a_to_g_right == 8'h00) && (rightseg == 4'b0000);
    assign w_blank      = w_left_zero && w_right_zero;
    assign w_valid      = (w_left_hit && w_right_zero) || (w_right_hit && w_left_zero);
    assign w_invalid    = !w_blank && !w_valid;
    assign w_dec_pos    = w_left_hit ? w_left_pos : w_right_pos;

    assign w_pos_next = (r_pos == c_POS_LAST) ? 5'd0 : r_pos + 5'd1;
    assign w_pos_prev = (r_pos == 5'd0) ? c_POS_LAST : r_pos - 5'd1;

    assign w_is_same = (w_dec_pos == r_pos);
    assign w_is_next = (w_dec_pos == w_pos_next);
    assign w_is_prev = (w_dec_pos == w_pos_prev);

    assign w_jump = sample_en && w_valid && (r_state != ST_HUNT)
                    && !w_is_same && !w_is_next && !w_is_prev;

    // A reversing move never counts, so the current dir must agree with the move
    assign w_lap_step = sample_en && w_valid && (r_state == ST_LOCKED)
                        && ((w_is_next && !r_dir && (r_pos == c_POS_LAST))
                         || (w_is_prev &&  r_dir && (r_pos == 5'd0)));

    assign w_err_event = (sample_en && w_invalid) || w_jump;
    assign w_err_sat   = &r_err_cnt;

    always_ff @(posedge clk_trl or posedge rst) begin
        if (rst) begin
            r_state       <= ST_HUNT;
            r_pos         <= 5'd0;
            r_pos_valid   <= 1'b0;
            r_dir         <= 1'b0;
            r_err_invalid <= 1'b0;
            r_err_jump    <= 1'b0;
        end else begin
            r_err_invalid <= 1'b0;
            r_err_jump    <= 1'b0;
            if (sample_en) begin
                if (w_invalid) begin
                    r_err_invalid <= 1'b1;
                    r_pos_valid   <= 1'b0;
                    r_state       <= ST_HUNT;
                end else if (w_valid) begin
                    case (r_state)
                        ST_HUNT: begin
                            r_pos       <= w_dec_pos;
                            r_pos_valid <= 1'b1;
                            r_state     <= ST_ACQUIRE;
                        end
                        ST_ACQUIRE: begin
                            if (w_is_next) begin
                                r_dir   <= 1'b0;
                                r_pos   <= w_dec_pos;
                                r_state <= ST_LOCKED;
                            end else if (w_is_prev) begin
                                r_dir   <= 1'b1;
                                r_pos   <= w_dec_pos;
                                r_state <= ST_LOCKED;
                            end else if (!w_is_same) begin
                                r_err_jump <= 1'b1;
                                r_pos      <= w_dec_pos;
                            end
                        end
                        ST_LOCKED: begin
                            if (w_is_next) begin
                                r_dir <= 1'b0;
                                r_pos <= w_dec_pos;
                            end else if (w_is_prev) begin
                                r_dir <= 1'b1;
                                r_pos <= w_dec_pos;
                            end else if (!w_is_same) begin
                                r_err_jump <= 1'b1;
                                r_pos      <= w_dec_pos;
                                r_state    <= ST_ACQUIRE;
                            end
                        end
                        default: begin
                            r_pos_valid <= 1'b0;
                            r_state     <= ST_HUNT;
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk_trl or posedge rst) begin
        if (rst) begin
            r_lap_cnt <= '0;
        end else if (w_lap_step) begin
            r_lap_cnt <= r_lap_cnt + LAP_W'(1);
        end
    end

    always_ff @(posedge clk_trl or posedge rst) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (w_err_event && !w_err_sat) begin
            r_err_cnt <= r_err_cnt + ERR_W'(1);
        end
    end

    assign pos         = r_pos;
    assign pos_valid   = r_pos_valid;
    assign dir         = r_dir;
    assign locked      = (r_state == ST_LOCKED);
    assign lap_cnt     = r_lap_cnt;
    assign err_invalid = r_err_invalid;
    assign err_jump    = r_err_jump;
    assign err_cnt     = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_snake_pos_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_snake_pos_decoder
// Description : Randomized, model-checked bench for snake_pos_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_snake_pos_decoder;

    logic       clk_trl;
    logic       rst;
    logic       sample_en;
    logic [7:0] a_to_g_left;
    logic [7:0] a_to_g_right;
    logic [3:0] leftseg;
    logic [3:0] rightseg;
    logic [4:0] pos;
    logic       pos_valid;
    logic       dir;
    logic       locked;
    logic [7:0] lap_cnt;
    logic       err_invalid;
    logic       err_jump;
    logic [7:0] err_cnt;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    snake_pos_decoder #(.LAP_W(8), .ERR_W(8)) dut (
        .clk_trl      (clk_trl),
        .rst          (rst),
        .sample_en    (sample_en),
        .a_to_g_left  (a_to_g_left),
        .a_to_g_right (a_to_g_right),
        .leftseg      (leftseg),
        .rightseg     (rightseg),
        .pos          (pos),
        .pos_valid    (pos_valid),
        .dir          (dir),
        .locked       (locked),
        .lap_cnt      (lap_cnt),
        .err_invalid  (err_invalid),
        .err_jump     (err_jump),
        .err_cnt      (err_cnt)
    );

    initial begin
        clk_trl = 1'b0;
        forever #5 clk_trl = ~clk_trl;
    end

    // Display pattern of every snake step: bank (1 = left), segment byte, select
    bit       t_left[20] = '{1,1,1,1, 0,0,0,0, 0,0,0,0,0,0, 1,1,1,1, 1,1};
    bit [7:0] t_seg[20]  = '{8'h80,8'h80,8'h80,8'h80, 8'h80,8'h80,8'h80,8'h80,
                             8'h40,8'h20,8'h10,8'h10,8'h10,8'h10,
                             8'h10,8'h10,8'h10,8'h10, 8'h08,8'h04};
    bit [3:0] t_sel[20]  = '{4'h8,4'h4,4'h2,4'h1, 4'h8,4'h4,4'h2,4'h1,
                             4'h1,4'h1,4'h1,4'h2,4'h4,4'h8,
                             4'h1,4'h2,4'h4,4'h8, 4'h8,4'h8};

    // -2 = blank, -1 = invalid, otherwise the snake position
    function automatic int classify(bit [7:0] l, bit [7:0] r, bit [3:0] ls, bit [3:0] rs);
        bit [23:0] v;
        bit [23:0] e;
        v = {l, ls, r, rs};
        if (v == 24'd0) return -2;
        for (int p = 0; p < 20; p++) begin
            e = t_left[p] ? {t_seg[p], t_sel[p], 12'd0} : {12'd0, t_seg[p], t_sel[p]};
            if (v == e) return p;
        end
        return -1;
    endfunction

    typedef struct packed {
        logic [4:0] pos;
        logic       valid;
        logic       dir;
        logic [1:0] mode;   // 0 searching, 1 acquiring, 2 locked
        logic [7:0] lap;
        logic       ei;
        logic       ej;
        logic [7:0] ec;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t model_step(mstate_t s, bit en, bit [7:0] l, bit [7:0] r,
                                           bit [3:0] ls, bit [3:0] rs);
        mstate_t n;
        int c;
        int d;
        n = s;
        n.ei = 0;
        n.ej = 0;
        if (!en) return n;
        c = classify(l, r, ls, rs);
        if (c == -2) return n;
        if (c == -1) begin
            n.ei = 1;
            n.valid = 0;
            n.mode = 0;
        end else begin
            d = (c - int'(s.pos) + 20) % 20;
            if (s.mode == 0) begin
                n.pos = 5'(c);
                n.valid = 1;
                n.mode = 1;
            end else if (d == 0) begin
                // same spot, nothing to do
            end else if (d == 1 || d == 19) begin
                if (s.mode == 2 && d == 1 && !s.dir && s.pos == 19) n.lap = s.lap + 8'd1;
                if (s.mode == 2 && d == 19 && s.dir && s.pos == 0) n.lap = s.lap + 8'd1;
                n.dir = (d == 19);
                n.pos = 5'(c);
                n.mode = 2;
            end else begin
                n.ej = 1;
                n.pos = 5'(c);
                n.mode = 1;
            end
        end
        if ((n.ei || n.ej) && s.ec != 8'd255) n.ec = s.ec + 8'd1;
        return n;
    endfunction

    always @(posedge clk_trl or posedge rst) begin
        if (rst) m <= '0;
        else     m <= model_step(m, sample_en, a_to_g_left, a_to_g_right, leftseg, rightseg);
    end

    always @(negedge clk_trl) begin
        if (cmp_en && !rst) begin
            checks++;
            if (pos !== m.pos || pos_valid !== m.valid || dir !== m.dir ||
                locked !== (m.mode == 2) || lap_cnt !== m.lap || err_invalid !== m.ei ||
                err_jump !== m.ej || err_cnt !== m.ec) begin
                errors++;
                $display("FAIL model_cmp t=%0t: got pos=%0d pv=%0b dir=%0b lk=%0b lap=%0d ei=%0b ej=%0b ec=%0d expected pos=%0d pv=%0b dir=%0b lk=%0b lap=%0d ei=%0b ej=%0b ec=%0d",
                         $time, pos, pos_valid, dir, locked, lap_cnt, err_invalid, err_jump, err_cnt,
                         m.pos, m.valid, m.dir, (m.mode == 2), m.lap, m.ei, m.ej, m.ec);
            end
        end
    end

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Each drive task is entered just after a falling edge and returns at the next one
    task automatic drive(bit en, bit [7:0] l, bit [7:0] r, bit [3:0] ls, bit [3:0] rs);
        sample_en = en;
        a_to_g_left = l;
        a_to_g_right = r;
        leftseg = ls;
        rightseg = rs;
        @(negedge clk_trl);
    endtask

    task automatic put_pos(int p);
        if (t_left[p]) drive(1, t_seg[p], 8'h00, t_sel[p], 4'h0);
        else           drive(1, 8'h00, t_seg[p], 4'h0, t_sel[p]);
    endtask

    task automatic put_blank();
        drive(1, 8'h00, 8'h00, 4'h0, 4'h0);
    endtask

    task automatic put_both();
        drive(1, 8'h80, 8'h80, 4'h8, 4'h1);
    endtask

    bit wdir = 0;

    initial begin
        rst = 1'b1;
        sample_en = 0;
        a_to_g_left = 0;
        a_to_g_right = 0;
        leftseg = 0;
        rightseg = 0;
        repeat (3) @(negedge clk_trl);
        rst = 1'b0;
        chk("reset_pos", pos, 0);
        chk("reset_pos_valid", pos_valid, 0);
        chk("reset_locked", locked, 0);
        chk("reset_lap", lap_cnt, 0);
        chk("reset_err_cnt", err_cnt, 0);
        cmp_en = 1;

        put_pos(0);
        chk("first_pos", pos, 0);
        chk("first_locked", locked, 0);
        put_pos(1);
        chk("second_pos", pos, 1);
        chk("second_dir", dir, 0);
        chk("second_locked", locked, 1);

        for (int p = 2; p < 20; p++) put_pos(p);
        chk("before_wrap_lap", lap_cnt, 0);
        put_pos(0);
        chk("lap_one", lap_cnt, 1);
        for (int p = 1; p < 20; p++) put_pos(p);
        put_pos(0);
        chk("lap_two", lap_cnt, 2);

        for (int p = 1; p <= 5; p++) put_pos(p);
        put_pos(5);
        chk("hold_same_pos", pos, 5);
        put_pos(4);
        chk("reverse_dir", dir, 1);
        chk("reverse_no_jump", err_jump, 0);
        chk("reverse_lap", lap_cnt, 2);
        chk("reverse_err_cnt", err_cnt, 0);
        for (int p = 3; p >= 0; p--) put_pos(p);
        put_pos(19);
        chk("lap_down", lap_cnt, 3);

        for (int p = 18; p >= 3; p--) put_pos(p);
        put_pos(9);
        chk("jump_pulse", err_jump, 1);
        chk("jump_err_cnt", err_cnt, 1);
        chk("jump_locked", locked, 0);
        chk("jump_pos", pos, 9);
        put_blank();
        chk("jump_pulse_clear", err_jump, 0);

        put_both();
        chk("both_invalid", err_invalid, 1);
        chk("both_pos_valid", pos_valid, 0);
        chk("both_err_cnt", err_cnt, 2);
        put_blank();
        put_blank();
        chk("blank_invalid_clear", err_invalid, 0);
        chk("blank_err_cnt", err_cnt, 2);
        chk("blank_lap_kept", lap_cnt, 3);

        for (int i = 0; i < 3000; i++) begin
            int r;
            int p;
            r = $urandom_range(0, 99);
            if (r < 12) begin
                drive(0, 8'($urandom), 8'($urandom), 4'($urandom), 4'($urandom));
            end else if (r < 60) begin
                if ($urandom_range(0, 9) == 0) wdir = ~wdir;
                p = wdir ? (int'(m.pos) + 19) % 20 : (int'(m.pos) + 1) % 20;
                put_pos(p);
            end else if (r < 68) begin
                put_pos(int'(m.pos));
            end else if (r < 76) begin
                put_pos($urandom_range(0, 19));
            end else if (r < 84) begin
                put_blank();
            end else if (r < 92) begin
                p = $urandom_range(0, 19);
                if (t_left[p]) drive(1, t_seg[p], 8'(1 << $urandom_range(0, 7)), t_sel[p], 4'h0);
                else           drive(1, t_seg[p], t_seg[p], t_sel[p], 4'($urandom));
            end else begin
                drive(1, 8'($urandom), 8'($urandom), 4'($urandom), 4'($urandom));
            end
        end

        for (int i = 0; i < 300; i++) put_both();
        chk("err_cnt_saturated", err_cnt, 255);
        chk("sat_invalid_pulse", err_invalid, 1);
        put_pos(10);
        put_pos(11);
        chk("relock_after_sat", locked, 1);

        #2 rst = 1'b1;
        #1;
        chk("async_rst_pos", pos, 0);
        chk("async_rst_locked", locked, 0);
        chk("async_rst_pos_valid", pos_valid, 0);
        chk("async_rst_lap", lap_cnt, 0);
        chk("async_rst_err_cnt", err_cnt, 0);
        @(negedge clk_trl);
        rst = 1'b0;
        put_pos(7);
        chk("post_rst_pos", pos, 7);
        chk("post_rst_pos_valid", pos_valid, 1);
        chk("post_rst_locked", locked, 0);
        put_pos(8);
        chk("post_rst_relock", locked, 1);
        put_blank();

        cmp_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
